change_dispenser: RTL
=====================

// Module: change_dispenser
//
// PURPOSE
//  Downstream of the ticket-sale stage (sell). When sell reports payment complete, this block
//  issues the purchased tickets one per cycle, then pays out change (total_money - cost_of_ticket)
//  as a greedy sequence of coins to the coin hopper over a valid/ready handshake.
//  It is the last stage before the physical ticket printer and coin hopper.
//
// PARAMETERS
//  DEN_A   50  largest coin value (must be > DEN_B)
//  DEN_B   10  second coin value (must be > DEN_C)
//  DEN_C   5   third coin value (must be > DEN_D)
//  DEN_D   1   smallest coin value; must be 1 so that any change amount is payable
//
// PORTS
//  clk             in   1  system clock, all logic on rising edge
//  reset           in   1  synchronous, active-high reset
//  start           in   1  one-cycle pulse from sell: payment settled, operands valid this cycle
//  total_money     in   8  total cash inserted (unsigned)
//  cost_of_ticket  in   8  total fare due for all tickets (unsigned)
//  ticket_count    in   3  number of tickets to issue (0..7)
//  busy            out  1  high from cycle after accepted start until cycle after done
//  ticket_out      out  1  one-cycle pulse per ticket issued
//  coin_valid      out  1  coin_value holds a coin to dispense
//  coin_value      out  6  value of current coin (DEN_A/B/C/D), 0 when coin_valid low
//  coin_ready      in   1  hopper accepts the coin this cycle
//  change_left     out  8  change still owed
//  done            out  1  one-cycle pulse: tickets and all change delivered
//  error           out  1  one-cycle pulse: start with total_money < cost_of_ticket
//
// BEHAVIOUR
//  - All outputs are registered. Reset values: busy=0, ticket_out=0, coin_valid=0, coin_value=0,
//    change_left=0, done=0, error=0. The state machine resets to IDLE.
//  - States: IDLE, TICKET, CHANGE, DONE.
//  - IDLE, start=1, total_money>=cost_of_ticket: latch change_left=total_money-cost_of_ticket
//    and the ticket count. Next state: TICKET if count>0; else CHANGE if change>0; else DONE.
//    busy=1 from the next cycle.
//  - IDLE, start=1, total_money<cost_of_ticket: error=1 for exactly one cycle, stay IDLE,
//    latch nothing.
//  - TICKET: ticket_out=1 on each of count consecutive cycles (the first is the cycle after start).
//    Then go to CHANGE if change_left>0, else go to DONE.
//  - CHANGE: coin_valid=1. coin_value is the largest DEN_x <= change_left.
//    - On coin_valid&&coin_ready: change_left -= coin_value. The next coin is shown the following
//      cycle, so there is no bubble.
//    - While coin_ready=0: coin_value and change_left hold stable.
//    - When the accepted coin makes change_left reach 0: coin_valid=0 and coin_value=0 next cycle,
//      and the state goes to DONE.
//  - DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
//  - start is ignored while busy=1 (no queueing).
//  - The subtraction is 8-bit unsigned and cannot underflow because total_money>=cost_of_ticket is
//    checked. The coin selection compares against the full 8-bit change_left.
//  - reset mid-operation: abort at once. Remaining tickets and change are dropped and outputs go to
//    their reset values on the next edge. No done or error is produced.
//
// TESTING
//  1. total=206, cost=160, tickets=4, coin_ready=1:
//     -> 4 ticket pulses, then coins 10,10,10,10,5,1 on consecutive cycles, then done. change_left 46->0.
//  2. total=100, cost=100, tickets=2 -> 2 ticket pulses, no coin_valid, done the cycle after the last
//     ticket.
//  3. total=50, cost=60, tickets=1 -> error one cycle, busy stays 0, no ticket_out or coin_valid.
//  4. total=57, cost=0, tickets=0, coin_ready low for 3 cycles then high:
//     -> coin_value=50 held stable for those 3 cycles, then 5,1,1, then done.
//  5. Mid-CHANGE (change_left=36): assert reset for 1 cycle -> all outputs 0, IDLE, no done.
//     A fresh start is then accepted normally.
//  6. Second start pulse while busy -> ignored. The first transaction completes unchanged with
//     exactly one done.

Source files
------------

// File: rtl/change_dispenser.sv
// Change dispenser: after payment settles, issues tickets one per cycle, then pays
// out the change as a greedy coin sequence over a valid/ready handshake.
module change_dispenser #(
  parameter int unsigned DEN_A = 50,
  parameter int unsigned DEN_B = 10,
  parameter int unsigned DEN_C = 5,
  parameter int unsigned DEN_D = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] total_money_i,
  input  logic [7:0] cost_of_ticket_i,
  input  logic [2:0] ticket_count_i,
  input  logic       coin_ready_i,
  output logic       busy_o,
  output logic       ticket_out_o,
  output logic       coin_valid_o,
  output logic [5:0] coin_value_o,
  output logic [7:0] change_left_o,
  output logic       done_o,
  output logic       error_o
);

  typedef enum logic [1:0] {StIdle, StTicket, StChange, StDone} state_e;

  state_e     state_q;
  logic [2:0] tickets_q;  // ticket pulses still to show, including the current one
  logic [7:0] change_q;
  logic       busy_q;
  logic       ticket_out_q;
  logic       coin_valid_q;
  logic [5:0] coin_value_q;
  logic       done_q;
  logic       error_q;

  logic       pay_ok;
  logic [7:0] change_init;
  logic [7:0] change_after;

  // Largest coin not exceeding the amount; zero only when the amount is zero.
  function automatic logic [5:0] pick_coin(input logic [7:0] amt);
    logic [5:0] coin;
    if (amt >= 8'(DEN_A)) begin
      coin = 6'(DEN_A);
    end else if (amt >= 8'(DEN_B)) begin
      coin = 6'(DEN_B);
    end else if (amt >= 8'(DEN_C)) begin
      coin = 6'(DEN_C);
    end else if (amt >= 8'(DEN_D)) begin
      coin = 6'(DEN_D);
    end else begin
      coin = '0;
    end
    return coin;
  endfunction

  // Operand checks and the remaining change once the shown coin is taken.
  always_comb begin
    pay_ok       = (total_money_i >= cost_of_ticket_i);
    change_init  = total_money_i - cost_of_ticket_i;
    change_after = change_q - 8'(coin_value_q);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      tickets_q    <= '0;
      change_q     <= '0;
      busy_q       <= 1'b0;
      ticket_out_q <= 1'b0;
      coin_valid_q <= 1'b0;
      coin_value_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            if (pay_ok) begin
              change_q  <= change_init;
              tickets_q <= ticket_count_i;
              busy_q    <= 1'b1;
              if (ticket_count_i != 3'd0) begin
                state_q      <= StTicket;
                ticket_out_q <= 1'b1;
              end else if (change_init != 8'd0) begin
                state_q      <= StChange;
                coin_valid_q <= 1'b1;
                coin_value_q <= pick_coin(change_init);
              end else begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end
            end else begin
              error_q <= 1'b1;
            end
          end
        end

        StTicket: begin
          if (tickets_q > 3'd1) begin
            tickets_q <= tickets_q - 3'd1;
          end else begin
            tickets_q    <= '0;
            ticket_out_q <= 1'b0;
            if (change_q != 8'd0) begin
              state_q      <= StChange;
              coin_valid_q <= 1'b1;
              coin_value_q <= pick_coin(change_q);
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end

        StChange: begin
          // Without coin_ready the shown coin and the owed change hold.
          if (coin_ready_i) begin
            change_q <= change_after;
            if (change_after == 8'd0) begin
              state_q      <= StDone;
              coin_valid_q <= 1'b0;
              coin_value_q <= '0;
              done_q       <= 1'b1;
            end else begin
              coin_value_q <= pick_coin(change_after);
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign ticket_out_o  = ticket_out_q;
  assign coin_valid_o  = coin_valid_q;
  assign coin_value_o  = coin_value_q;
  assign change_left_o = change_q;
  assign done_o        = done_q;
  assign error_o       = error_q;

endmodule
